array_seq: RTL
==============

# array_seq

Sequencer for the SIZE×SIZE MAC array. It runs one matrix job per `start`:
- clears the accumulators;
- streams K operand beats into the array corner with `mult_en`/`acc_en` gating;
- drains the systolic skew;
- scans all SIZE*SIZE accumulators through the array's `select`/`d_out` read mux into a ready/valid result stream.

It sits between the command/operand front end and the array instance. It is the only driver of the array's control and operand inputs.

## Interface
- SIZE, 16, array dimension; must match the array instance
- DRAIN, 2*SIZE-1, idle-operand cycles after the last beat so skewed operands reach element (SIZE-1,SIZE-1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous active-low reset (0 = reset)
- start  in  1  job request pulse; accepted only in IDLE
- k_len  in  8  beats in the job, sampled with start
- abort  in  1  synchronous abort, any non-IDLE state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a job completes or is aborted
- op_valid  in  1  operand beat present
- op_a, op_b  in  8 each  operand beat
- op_ready  out  1  beat accepted when op_valid&&op_ready
- a_in, b_in  out  8 each  to array corner
- mult_en, acc_en, load_en  out  1 each  to array
- select  out  SIZE*SIZE  to array; element index zero-extended
- d_out  in  32  read data from array, combinational in select
- res_valid  out  1  result word present
- res_ready  in  1  sink accepts result
- res_data  out  32  accumulator value
- res_idx  out  $clog2(SIZE*SIZE)  element index i*SIZE+j of res_data
- res_last  out  1  high with the final result word

## Operation
- **States.** IDLE → CLEAR → FEED → DRAIN → READ → DONE → IDLE.
- **IDLE**
  - All array controls are 0.
  - `start` latches k_len, then goes to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `load_en`=1 zeroes every accumulator.
  - Then goes to FEED, or to DRAIN if k_len==0.
- **FEED**
  - `op_ready`=1 while the beat counter < k_len.
  - On an accepted beat: `a_in`=op_a, `b_in`=op_b, `mult_en`=`acc_en`=1, and the counter increments.
  - Stall cycle (op_valid=0): `a_in`=`b_in`=0, `mult_en`=`acc_en`=0.
  - After beat k_len is accepted, goes to DRAIN.
- **DRAIN** (DRAIN cycles)
  - `a_in`=`b_in`=0, `mult_en`=`acc_en`=1.
  - Zero operands add nothing to the accumulators; the enables keep operands shifting.
- **READ**
  - Index counter idx runs 0..SIZE*SIZE-1; `select`=idx.
  - Capture when !res_valid || res_ready:
    - res_data←d_out, res_idx←idx, res_valid←1;
    - res_last←(idx==SIZE*SIZE-1);
    - idx increments.
  - After the res_last word handshakes, goes to DONE.
  - res_valid drops unless a new capture occurs the same cycle.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **abort**
  - In any non-IDLE state: next state is DONE.
  - All array enables are 0 from the next cycle; res_valid clears.
  - Accumulator contents are undefined for the aborted job.
- **start handling**
  - `start` outside IDLE is ignored.
  - `start` and `abort` in the same cycle in IDLE: start wins; abort is meaningless in IDLE.
- **Stream stability**
  - res_data, res_idx and res_last hold stable while res_valid && !res_ready.

## Timing
- Reset values: state=IDLE, all counters 0. All outputs are 0: busy, done, op_ready, a_in, b_in, mult_en, acc_en, load_en, select, res_valid, res_data, res_idx, res_last.
- An asynchronous reset mid-job returns to IDLE immediately. No done pulse is produced.
- Control and operand outputs are registered. The array sees a beat one cycle after its handshake.
- Job latency, no stalls and no backpressure: start@0; CLEAR@1; FEED@2..k+1; DRAIN for DRAIN cycles; first res_valid one cycle after READ entry; one result per cycle; done one cycle after the res_last handshake.
- Throughput in READ is 1 word/cycle with res_ready held high.
- Bubble-free backpressure: the capture enable is !res_valid||res_ready.
- The index counter is exactly wide enough for SIZE*SIZE-1 and never wraps. READ exit is on the res_last handshake, not on counter overflow.
- k_len=255 is legal. The beat counter is 8 bits and compares against k_len, so there is no wrap.

## Structure
- Shared package `array_pkg`:
  - state enum `array_seq_state_t` {IDLE, CLEAR, FEED, DRAIN, READ, DONE};
  - constants IDX_W=$clog2(SIZE*SIZE) and default DRAIN;
  - the 32-bit accumulator width.
- Sub-module `array_readout`: the READ-state index counter plus the res_* skid register and handshake. Its interface is go/idx/d_out/res_*/finished.

## Test plan
Benches use SIZE=2 with a behavioural array model.
- **Reset:** drive reset=0 mid-FEED with k_len=4 → all outputs 0 in the same cycle; state IDLE after release; no done.
- **Single beat:** k_len=1, beat a=3,b=4 → load_en one cycle; first result res_idx=0, res_data=12; 4 words total; res_last on idx 3; done one cycle after the last handshake.
- **Stalls:** k_len=3 with beats (1,2),(3,4),(5,6) and op_valid low 2 cycles between beats → mult_en low exactly on stall cycles; element 0 = 44.
- **Backpressure:** res_ready toggles 1,0,0,1… → no word lost or duplicated; res_idx sequence 0,1,2,3; data stable while stalled.
- **Abort:** abort during DRAIN → done next cycle; enables 0; busy low afterward; a new start then runs normally.
- **Edges:** k_len=0 → CLEAR then DRAIN; all results 0. start while busy → ignored; job count unchanged.

Source files
------------

// File: rtl/array_pkg.sv
// Shared types and constants for the MAC array sequencer.
package array_pkg;

  localparam int SIZE_DEFAULT  = 16;
  localparam int IDX_W         = $clog2(SIZE_DEFAULT * SIZE_DEFAULT);
  localparam int DRAIN_DEFAULT = 2 * SIZE_DEFAULT - 1;
  localparam int ACC_W         = 32;

  // state    | meaning
  // IDLE     | waiting for start, array controls held at 0
  // CLEAR    | one cycle of load_en to zero the accumulators
  // FEED     | accepting k_len operand beats
  // DRAIN    | zero operands with enables high so the skew empties
  // READ     | scanning accumulators into the result stream
  // DONE     | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    READ,
    DONE
  } array_seq_state_t;

  // Width of an element index for a size x size array.
  function automatic int idx_width(input int size);
    return $clog2(size * size);
  endfunction

endpackage

// File: rtl/array_readout.sv
// Accumulator scan: walks idx over every element and presents d_out on a
// ready/valid stream through a single output register.
module array_readout
  import array_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          go,
  input  logic [ACC_W-1:0]              d_out,
  input  logic                          res_ready,
  output logic [$clog2(SIZE*SIZE)-1:0]  idx,
  output logic                          res_valid,
  output logic [ACC_W-1:0]              res_data,
  output logic [$clog2(SIZE*SIZE)-1:0]  res_idx,
  output logic                          res_last,
  output logic                          finished
);

  localparam int            IW       = idx_width(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE * SIZE - 1);

  // all_sent stops further captures once the final element has been taken,
  // so idx parks on the last element instead of wrapping.
  logic all_sent;
  logic capture;

  assign capture  = go && !all_sent && (!res_valid || res_ready);
  assign finished = go && res_valid && res_ready && res_last;

  // Index counter and result register; everything but the data clears when
  // the scan is not running so an abort drops res_valid at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      all_sent  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
    end else if (!go) begin
      idx       <= '0;
      all_sent  <= 1'b0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= d_out;
      res_idx   <= idx;
      res_last  <= (idx == LAST_IDX);
      if (idx == LAST_IDX) begin
        all_sent <= 1'b1;
      end else begin
        idx <= idx + IW'(1);
      end
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/array_seq.sv
// Job sequencer for the SIZE x SIZE MAC array: clear, feed K beats, drain
// the skew, then stream every accumulator out.
//
// state    | meaning
// IDLE     | waiting for start, array controls held at 0
// CLEAR    | load_en high for one cycle
// FEED     | op_ready while beats remain; accepted beats go to the corner
// DRAIN    | DRAIN cycles of zero operands with enables high
// READ     | array_readout scans all elements
// DONE     | done pulse, then back to IDLE
module array_seq
  import array_pkg::*;
#(
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int DRAIN = 2 * SIZE - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    k_len,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  input  logic                          op_valid,
  input  logic [7:0]                    op_a,
  input  logic [7:0]                    op_b,
  output logic                          op_ready,
  output logic [7:0]                    a_in,
  output logic [7:0]                    b_in,
  output logic                          mult_en,
  output logic                          acc_en,
  output logic                          load_en,
  output logic [SIZE*SIZE-1:0]          select,
  input  logic [ACC_W-1:0]              d_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ACC_W-1:0]              res_data,
  output logic [$clog2(SIZE*SIZE)-1:0]  res_idx,
  output logic                          res_last
);

  localparam int            IW         = idx_width(SIZE);
  localparam int            SEL_W      = SIZE * SIZE;
  localparam int            DW         = $clog2(DRAIN + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN - 1);

  array_seq_state_t state;
  array_seq_state_t state_nx;

  logic [7:0]    k_q;
  logic [7:0]    beat_cnt;
  logic [DW-1:0] drain_cnt;
  logic          feed_hs;
  logic          last_beat;
  logic          go;
  logic          finished;
  logic [IW-1:0] idx;
  logic [7:0]    a_q;
  logic [7:0]    b_q;
  logic          en_q;
  logic          load_q;

  // The enum literal DRAIN is spelled with its package scope here because
  // the DRAIN parameter shares the name.
  assign op_ready  = (state == FEED) && (beat_cnt < k_q);
  assign feed_hs   = op_ready && op_valid;
  assign last_beat = ({1'b0, beat_cnt} + 9'd1) == {1'b0, k_q};
  assign go        = (state == READ) && !abort;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign a_in    = a_q;
  assign b_in    = b_q;
  assign mult_en = en_q;
  assign acc_en  = en_q;
  assign load_en = load_q;
  assign select  = {{(SEL_W - IW){1'b0}}, idx};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; abort overrides everything except IDLE and DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:             if (start) state_nx = CLEAR;
      CLEAR:            state_nx = (k_q == 8'd0) ? array_pkg::DRAIN : FEED;
      FEED:             if (feed_hs && last_beat) state_nx = array_pkg::DRAIN;
      array_pkg::DRAIN: if (drain_cnt == '0) state_nx = READ;
      READ:             if (finished) state_nx = DONE;
      DONE:             state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
    if (abort && (state != IDLE) && (state != DONE)) begin
      state_nx = DONE;
    end
  end

  // Job length latch, beat up-counter and drain down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        k_q      <= k_len;
        beat_cnt <= '0;
      end else if (feed_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if ((state != array_pkg::DRAIN) && (state_nx == array_pkg::DRAIN)) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == array_pkg::DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DW'(1);
      end
    end
  end

  // Registered array controls: a beat reaches the corner the cycle after its
  // handshake, and DRAIN keeps the enables high with zero operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      en_q   <= 1'b0;
      load_q <= 1'b0;
    end else begin
      a_q    <= '0;
      b_q    <= '0;
      en_q   <= 1'b0;
      load_q <= (state == IDLE) && start;
      if (!abort) begin
        if (feed_hs) begin
          a_q  <= op_a;
          b_q  <= op_b;
          en_q <= 1'b1;
        end else if (state == array_pkg::DRAIN) begin
          en_q <= 1'b1;
        end
      end
    end
  end

  array_readout #(
    .SIZE (SIZE)
  ) u_readout (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .d_out     (d_out),
    .res_ready (res_ready),
    .idx       (idx),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_last  (res_last),
    .finished  (finished)
  );

endmodule
